// File: rtl/mem_access_unit.sv
// Memory-stage load/store controller: byte-address to word-index translation,
// alignment/range checking, extended loads and read-modify-write sub-dword stores.
module mem_access_unit #(
  parameter int n     = 64,
  parameter int depth = 256
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_write,
  input  logic [1:0]   req_size,
  input  logic         req_signed,
  input  logic [n-1:0] req_addr,
  input  logic [n-1:0] req_wdata,
  output logic         resp_valid,
  output logic         resp_err,
  output logic [n-1:0] resp_rdata,
  output logic [n-1:0] mem_address,
  output logic         mem_read,
  output logic         mem_write,
  output logic [n-1:0] mem_din,
  input  logic [n-1:0] mem_dout
);

  typedef enum logic [2:0] {IDLE, LOAD, STORE, RMW_RD, RMW_WR} state_t;

  state_t       state, next_state;
  logic [n-1:0] addr_q, wdata_q, merge_q;
  logic [1:0]   size_q;
  logic         signed_q;

  logic         accept, misaligned, out_of_range, req_err;
  logic [5:0]   shamt;
  logic [n-1:0] field_mask, shifted, load_val;

  assign req_ready    = (state == IDLE);
  assign accept       = req_valid & req_ready;
  assign out_of_range = (req_addr[n-1:3] >= (n-3)'(depth));
  assign req_err      = misaligned | out_of_range;

  always_comb begin
    misaligned = 1'b0;
    case (req_size)
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = |req_addr[1:0];
      2'b11:   misaligned = |req_addr[2:0];
      default: misaligned = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept && !req_err) begin
          if (!req_write)             next_state = LOAD;
          else if (req_size == 2'b11) next_state = STORE;
          else                        next_state = RMW_RD;
        end
      end
      RMW_RD:  next_state = RMW_WR;
      default: next_state = IDLE;
    endcase
  end

  // Little-endian lane select: field of size_q bytes at byte offset addr_q[2:0].
  assign shamt   = {addr_q[2:0], 3'b000};
  assign shifted = mem_dout >> shamt;

  always_comb begin
    field_mask = '0;
    load_val   = '0;
    case (size_q)
      2'b00: begin
        field_mask = n'(64'h0000_0000_0000_00ff);
        load_val   = {{(n-8){signed_q & shifted[7]}}, shifted[7:0]};
      end
      2'b01: begin
        field_mask = n'(64'h0000_0000_0000_ffff);
        load_val   = {{(n-16){signed_q & shifted[15]}}, shifted[15:0]};
      end
      2'b10: begin
        field_mask = n'(64'h0000_0000_ffff_ffff);
        load_val   = {{(n-32){signed_q & shifted[31]}}, shifted[31:0]};
      end
      default: begin
        field_mask = '1;
        load_val   = shifted;
      end
    endcase
  end

  assign mem_address = {3'b000, addr_q[n-1:3]};
  assign mem_read    = (state == LOAD)  || (state == RMW_RD);
  assign mem_write   = (state == STORE) || (state == RMW_WR);

  always_comb begin
    mem_din = '0;
    case (state)
      STORE:   mem_din = wdata_q;
      RMW_WR:  mem_din = (merge_q & ~(field_mask << shamt)) | ((wdata_q & field_mask) << shamt);
      default: mem_din = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      merge_q    <= '0;
      size_q     <= '0;
      signed_q   <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      if (accept) begin
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        size_q   <= req_size;
        signed_q <= req_signed;
        if (req_err) begin
          resp_valid <= 1'b1;
          resp_err   <= 1'b1;
        end
      end
      case (state)
        LOAD: begin
          resp_rdata <= load_val;
          resp_valid <= 1'b1;
        end
        STORE, RMW_WR: resp_valid <= 1'b1;
        RMW_RD:        merge_q    <= mem_dout;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural word-addressed data memory.
module tb_mem_access_unit;

  logic        clk, rst_n;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [63:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [63:0] resp_rdata, mem_address, mem_din;
  logic        mem_read, mem_write;
  wire  [63:0] mem_dout;

  logic [63:0] mem [0:255];
  int          wr_cnt = 0;
  int          pulses = 0;
  int          n_checks = 0;
  int          n_err = 0;
  int          p0, w0;

  mem_access_unit #(.n(64), .depth(256)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_rdata(resp_rdata), .mem_address(mem_address), .mem_read(mem_read),
    .mem_write(mem_write), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_dout = mem_read ? mem[mem_address[7:0]] : 'z;

  always @(posedge clk) begin
    if (mem_write) begin
      mem[mem_address[7:0]] <= mem_din;
      wr_cnt <= wr_cnt + 1;
    end
  end

  always @(negedge clk) if (resp_valid === 1'b1) pulses <= pulses + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [63:0] a, input logic [63:0] d);
    req_valid  = 1'b1;
    req_write  = w;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = d;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    rst_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0;
    @(posedge clk); #1;
    chk("rst_ready", 64'(req_ready), 64'd1);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_err", 64'(resp_err), 64'd0);
    chk("rst_rdata", resp_rdata, 64'd0);
    chk("rst_mem_rw", {62'd0, mem_read, mem_write}, 64'd0);
    chk("rst_mem_address", mem_address, 64'd0);
    chk("rst_mem_din", mem_din, 64'd0);
    #2 rst_n = 1'b1;
    tick();
    chk("idle_quiet", {61'd0, resp_valid, mem_read, mem_write}, 64'd0);

    // Dword store then load
    issue(1'b1, 2'b11, 1'b0, 64'h18, 64'h0123456789ABCDEF);
    tick();
    req_valid = 1'b0;
    chk("st_ready", 64'(req_ready), 64'd0);
    chk("st_mem_write", 64'(mem_write), 64'd1);
    chk("st_mem_address", mem_address, 64'd3);
    chk("st_mem_din", mem_din, 64'h0123456789ABCDEF);
    chk("st_resp_early", 64'(resp_valid), 64'd0);
    tick();
    chk("st_resp", {62'd0, resp_valid, resp_err}, 64'd2);
    chk("st_write_done", 64'(mem_write), 64'd0);
    chk("st_mem3", mem[3], 64'h0123456789ABCDEF);
    tick();
    chk("st_pulse_one", 64'(resp_valid), 64'd0);

    issue(1'b0, 2'b11, 1'b0, 64'h18, 64'h0);
    tick();
    req_valid = 1'b0;
    chk("ld_mem_read", 64'(mem_read), 64'd1);
    chk("ld_ready", 64'(req_ready), 64'd0);
    tick();
    chk("ld_resp", {62'd0, resp_valid, resp_err}, 64'd2);
    chk("ld_dword", resp_rdata, 64'h0123456789ABCDEF);

    // Extended loads
    issue(1'b0, 2'b00, 1'b1, 64'h1A, 64'h0);
    tick(); req_valid = 1'b0; tick();
    chk("ld_byte_s", resp_rdata, 64'hFFFFFFFFFFFFFFAB);
    issue(1'b0, 2'b00, 1'b0, 64'h1A, 64'h0);
    tick(); req_valid = 1'b0; tick();
    chk("ld_byte_u", resp_rdata, 64'h00000000000000AB);
    issue(1'b0, 2'b10, 1'b1, 64'h1C, 64'h0);
    tick(); req_valid = 1'b0; tick();
    chk("ld_word_s", resp_rdata, 64'h0000000001234567);
    issue(1'b0, 2'b01, 1'b1, 64'h18, 64'h0);
    tick(); req_valid = 1'b0; tick();
    chk("ld_half_s", resp_rdata, 64'hFFFFFFFFFFFFCDEF);

    // Half RMW store
    issue(1'b1, 2'b01, 1'b0, 64'h1C, 64'h1111222233330000 | 64'hBEEF);
    tick();
    req_valid = 1'b0;
    chk("rmw_rd", {62'd0, mem_read, mem_write}, 64'd2);
    chk("rmw_rd_resp", 64'(resp_valid), 64'd0);
    tick();
    chk("rmw_wr", {62'd0, mem_read, mem_write}, 64'd1);
    chk("rmw_din", mem_din, 64'h0123BEEF89ABCDEF);
    chk("rmw_wr_resp", 64'(resp_valid), 64'd0);
    tick();
    chk("rmw_resp", {62'd0, resp_valid, resp_err}, 64'd2);
    chk("rmw_mem3", mem[3], 64'h0123BEEF89ABCDEF);

    // Byte RMW at the top lane
    issue(1'b1, 2'b00, 1'b0, 64'h1F, 64'hFFFFFFFFFFFFFFA5);
    tick(); req_valid = 1'b0; tick();
    chk("rmw_b_din", mem_din, 64'hA523BEEF89ABCDEF);
    tick();
    chk("rmw_b_mem3", mem[3], 64'hA523BEEF89ABCDEF);

    // Error responses
    w0 = wr_cnt;
    issue(1'b0, 2'b10, 1'b0, 64'h1E, 64'h0);
    tick();
    req_valid = 1'b0;
    chk("err_mis_resp", {62'd0, resp_valid, resp_err}, 64'd3);
    chk("err_mis_ready", 64'(req_ready), 64'd1);
    chk("err_mis_mem", {62'd0, mem_read, mem_write}, 64'd0);
    chk("err_mis_rdata", resp_rdata, 64'hFFFFFFFFFFFFCDEF);
    tick();
    chk("err_pulse_one", {62'd0, resp_valid, resp_err}, 64'd0);
    issue(1'b0, 2'b11, 1'b0, 64'h800, 64'h0);
    tick();
    req_valid = 1'b0;
    chk("err_range", {62'd0, resp_valid, resp_err}, 64'd3);
    chk("err_range_mem", {62'd0, mem_read, mem_write}, 64'd0);
    tick();
    issue(1'b1, 2'b01, 1'b0, 64'h19, 64'h1234);
    tick();
    req_valid = 1'b0;
    chk("err_st_resp", {62'd0, resp_valid, resp_err}, 64'd3);
    tick();
    chk("err_no_write", 64'(wr_cnt - w0), 64'd0);
    issue(1'b0, 2'b11, 1'b0, 64'h7F8, 64'h0);
    tick(); req_valid = 1'b0; tick();
    chk("last_idx_resp", {62'd0, resp_valid, resp_err}, 64'd2);
    chk("last_idx_rdata", resp_rdata, 64'd0);
    tick();

    // Back-to-back loads with req_valid held high
    p0 = pulses;
    issue(1'b0, 2'b11, 1'b0, 64'h18, 64'h0);
    tick();
    chk("b2b_a_ready", 64'(req_ready), 64'd0);
    issue(1'b0, 2'b00, 1'b0, 64'h1B, 64'h0);
    tick();
    chk("b2b_a_resp", {62'd0, resp_valid, req_ready}, 64'd3);
    chk("b2b_a_rdata", resp_rdata, 64'hA523BEEF89ABCDEF);
    tick();
    chk("b2b_b_ready", {62'd0, resp_valid, req_ready}, 64'd0);
    issue(1'b0, 2'b01, 1'b1, 64'h1E, 64'h0);
    tick();
    chk("b2b_b_rdata", resp_rdata, 64'h0000000000000089);
    tick();
    chk("b2b_c_ready", 64'(req_ready), 64'd0);
    req_valid = 1'b0;
    tick();
    chk("b2b_c_rdata", resp_rdata, 64'hFFFFFFFFFFFFA523);
    tick(); tick();
    chk("b2b_pulses", 64'(pulses - p0), 64'd3);

    // Reset during RMW_RD of a byte store
    w0 = wr_cnt;
    issue(1'b1, 2'b00, 1'b0, 64'h18, 64'h77);
    tick();
    req_valid = 1'b0;
    chk("rst_mid_rmw_rd", 64'(mem_read), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_mem", {62'd0, mem_read, mem_write}, 64'd0);
    chk("rst_mid_ready", 64'(req_ready), 64'd1);
    chk("rst_mid_rdata", resp_rdata, 64'd0);
    chk("rst_mid_addr", mem_address, 64'd0);
    tick(); tick();
    #2 rst_n = 1'b1;
    tick();
    chk("rst_mid_no_write", 64'(wr_cnt - w0), 64'd0);
    chk("rst_mid_resp", 64'(resp_valid), 64'd0);
    issue(1'b0, 2'b11, 1'b0, 64'h18, 64'h0);
    tick(); req_valid = 1'b0; tick();
    chk("rst_mid_word_kept", resp_rdata, 64'hA523BEEF89ABCDEF);
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage load/store controller between the EX/MEM pipeline register and the word-addressed data memory (n-bit words, `depth` entries, combinational read, write on posedge `clk`).
- Converts byte addresses to word indices and checks alignment and range.
- Performs byte, half, word and dword loads with sign or zero extension.
- Performs sub-dword stores as a read-modify-write sequence.
- Handles one request at a time, with a valid/ready request handshake and a single-cycle response pulse.

Parameters:
- n, 64, data width; must be 64.
- depth, 256, data memory entries; word index = byte address[63:3].

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_write  in  1  1=store, 0=load
- req_size  in  2  00 byte, 01 half, 10 word, 11 dword
- req_signed  in  1  sign-extend load result (ignored for dword and stores)
- req_addr  in  n  byte address
- req_wdata  in  n  store data; the active field is in the low bits
- resp_valid  out  1  one-cycle completion pulse
- resp_err  out  1  qualifies resp_valid; misaligned or out-of-range access
- resp_rdata  out  n  load result; held until the next load response
- mem_address  out  n  word index to data memory: zero-extended req_addr[63:3]
- mem_read  out  1  data memory read enable
- mem_write  out  1  data memory write enable
- mem_din  out  n  data memory write data
- mem_dout  in  n  data memory read data; high-Z when mem_read=0

Behaviour:
- Reset values (asynchronous, on rst_n low):
  - state=IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0.
  - mem_read=0, mem_write=0, mem_address=0, mem_din=0.
- Acceptance: a request is accepted on a posedge with req_valid & req_ready. At that edge all req_* fields are latched into internal registers.
- req_ready=1 only in IDLE. The upstream pipeline stalls while it is low.
- Error check at acceptance, using the request inputs:
  - Misaligned: addr[0]≠0 for half, addr[1:0]≠0 for word, addr[2:0]≠0 for dword.
  - Out of range: addr[63:3] ≥ depth.
  - On either error: resp_valid=1 and resp_err=1 after that same edge. The unit stays IDLE, makes no memory access, and leaves resp_rdata unchanged.
- States: IDLE, LOAD, STORE, RMW_RD, RMW_WR.
  - Valid load → LOAD.
  - Valid dword store → STORE.
  - Valid byte/half/word store → RMW_RD → RMW_WR.
  - LOAD, STORE and RMW_WR each return to IDLE after one cycle.
- mem_read, mem_write and mem_din are combinational decodes of the state and the latched registers.
  - mem_read=1 in LOAD and RMW_RD only.
  - mem_write=1 in STORE and RMW_WR only.
  - mem_dout is sampled only when mem_read=1.
- Lane mapping (little-endian): byte offset o=addr[2:0], shift s=8*o.
- LOAD:
  - At the end-of-cycle edge, resp_rdata = extend((mem_dout >> s) masked to size).
  - Extension is sign- or zero-extension according to req_signed.
  - resp_valid=1, resp_err=0 for the following cycle; state returns to IDLE. Latency: response one cycle after acceptance.
- STORE: mem_din=wdata. Memory updates at the closing edge, after which resp_valid pulses.
- RMW_RD: the read word is captured into a merge register.
- RMW_WR:
  - mem_din = merge register with the size-field at offset o replaced by wdata[field-1:0]; all other bytes are preserved.
  - resp_valid pulses after the closing edge, two cycles after acceptance.
- resp_valid is high for exactly one cycle per accepted request. A new request may be accepted in the same cycle resp_valid is high, because req_ready=1 then.
- resp_err is 0 whenever resp_valid=0.
- Reset mid-operation: immediately forces IDLE and deasserts mem_write combinationally, so no write edge occurs. The in-flight request is dropped with no response. A memory word partially handled in RMW keeps its old value.
- req_valid deasserted in IDLE: no state change, all outputs quiescent.

Test Plan:
- Dword store then load: store addr=0x18, wdata=0x0123456789ABCDEF.
  - mem_address=3, mem_write for one cycle, resp_valid one cycle later.
  - Load of addr 0x18 → resp_rdata=0x0123456789ABCDEF, one cycle after acceptance.
- Signed byte load: memory word 3 = 0x0123456789ABCDEF; load byte addr=0x1A.
  - Signed → resp_rdata=0xFFFFFFFFFFFFFFAB.
  - Unsigned → 0x00000000000000AB.
- Half RMW store: store half addr=0x1C, wdata=0xBEEF onto 0x0123456789ABCDEF.
  - Sequence RMW_RD then RMW_WR; mem_din=0x0123BEEF89ABCDEF; resp_valid two cycles after acceptance.
- Errors:
  - Word load at addr=0x1E → resp_err=1 pulse on the next cycle, no mem_read/mem_write, resp_rdata unchanged.
  - Dword load at addr=0x800 (index 256) → resp_err=1.
- Back-to-back handshake: hold req_valid high with three loads.
  - req_ready low during each LOAD cycle.
  - Exactly three resp_valid pulses, with accepts in cycles 0, 2 and 4.
- Reset in RMW_RD: assert rst_n=0 during RMW_RD of a byte store.
  - mem_write never goes high; outputs reach reset values immediately; target word is unchanged on a later read.
